// File: rtl/raster_pkg.sv
// Shared definitions for the raster engine: command codes, FSM states,
// framebuffer geometry and a coordinate clipping helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package raster_pkg;

  localparam int FB_W    = 8;
  localparam int FB_H    = 8;
  localparam int COORD_W = 3;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_PIXEL = 2'b01,
    CMD_LINE  = 2'b10,
    CMD_RECT  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PIXEL = 3'd2,
    ST_LINE  = 3'd3,
    ST_RECT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Map a command code onto the state that executes it.
  function automatic state_e cmd_to_state(input logic [1:0] c);
    state_e s;
    case (c)
      2'b00:   s = ST_CLEAR;
      2'b01:   s = ST_PIXEL;
      2'b10:   s = ST_LINE;
      default: s = ST_RECT;
    endcase
    return s;
  endfunction

  // Last coordinate covered by base..base+ext, saturating at the edge
  // of the framebuffer instead of wrapping.
  function automatic logic [COORD_W-1:0] clip_end(input logic [COORD_W-1:0] base,
                                                  input logic [COORD_W-1:0] ext);
    logic [COORD_W:0] sum;
    sum = {1'b0, base} + {1'b0, ext};
    return sum[COORD_W] ? {COORD_W{1'b1}} : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham line walker: emits one pixel coordinate per cycle from the
// start point to the end point inclusive, in any octant.
// Latency: first point valid the cycle after load. Backpressure: none, steps every cycle.
// Ports: clk, rst_n (sync, active-low); load + x/y start/end in;
//        cur_x, cur_y, valid (point present), last (point is the end point) out.
module line_stepper
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W-1:0] x_end,
  input  logic [COORD_W-1:0] y_end,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               valid,
  output logic               last
);

  logic [COORD_W-1:0] xe_q, ye_q;
  logic signed [4:0]  dx_q, dy_q, err_q;   // dx >= 0, dy <= 0
  logic               sx_neg, sy_neg;

  logic signed [4:0]  ddx, ddy, adx, ady, err_nxt;
  logic signed [5:0]  e2, dx6, dy6;
  logic               step_x, step_y;

  always_comb begin
    ddx = $signed({2'b00, x_end}) - $signed({2'b00, x_start});
    ddy = $signed({2'b00, y_end}) - $signed({2'b00, y_start});
    adx = ddx[4] ? -ddx : ddx;
    ady = ddy[4] ? -ddy : ddy;
    e2  = {err_q, 1'b0};
    dx6 = {dx_q[4], dx_q};
    dy6 = {dy_q[4], dy_q};
    // Both tests use the same e2; equality advances the axis, so a tie
    // moves the minor coordinate.
    step_x  = (e2 >= dy6);
    step_y  = (e2 <= dx6);
    err_nxt = err_q + (step_x ? dy_q : 5'sd0) + (step_y ? dx_q : 5'sd0);
    last    = valid && (cur_x == xe_q) && (cur_y == ye_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      cur_x  <= '0;
      cur_y  <= '0;
      xe_q   <= '0;
      ye_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      err_q  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      cur_x  <= x_start;
      cur_y  <= y_start;
      xe_q   <= x_end;
      ye_q   <= y_end;
      dx_q   <= adx;
      dy_q   <= -ady;
      err_q  <= adx - ady;
      sx_neg <= ddx[4];
      sy_neg <= ddy[4];
    end else if (valid) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        if (step_x) cur_x <= sx_neg ? cur_x - 3'd1 : cur_x + 3'd1;
        if (step_y) cur_y <= sy_neg ? cur_y - 3'd1 : cur_y + 3'd1;
        err_q <= err_nxt;
      end
    end
  end

endmodule

// File: rtl/raster_engine.sv
// 8x8 monochrome rasteriser: CLEAR, PIXEL, LINE and RECT commands drawn
// one pixel (or one row for CLEAR) per cycle into a 64-bit framebuffer.
// Latency: busy the cycle after accept, DONE one cycle after last write. Backpressure: commands while busy are dropped.
// Ports: clk, rst_n (sync, active-low); cmd_valid, cmd, x1/y1/x2/y2/width/height
//        command in; rd_row in, rd_data registered row out; busy, done, drop status.
module raster_engine
  import raster_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [2:0] x1,
  input  logic [2:0] y1,
  input  logic [2:0] x2,
  input  logic [2:0] y2,
  input  logic [2:0] width,
  input  logic [2:0] height,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       drop
);

  state_e state_q, state_d;
  logic   accept;

  logic [FB_W*FB_H-1:0] fb;

  // cx/cy walk RECT (and hold the PIXEL point); cy alone is the CLEAR row.
  logic [COORD_W-1:0] cx, cy, x_lo_q, x_hi_q, y_hi_q;

  logic [COORD_W-1:0] ln_x, ln_y;
  logic               ln_valid, ln_last;

  line_stepper u_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && (cmd == CMD_LINE)),
    .x_start (x1),
    .y_start (y1),
    .x_end   (x2),
    .y_end   (y2),
    .cur_x   (ln_x),
    .cur_y   (ln_y),
    .valid   (ln_valid),
    .last    (ln_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        accept  = cmd_valid;
        state_d = cmd_valid ? cmd_to_state(cmd) : ST_IDLE;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        drop = cmd_valid;
        if (cy == 3'd7) state_d = ST_DONE;
      end
      ST_PIXEL: begin
        busy    = 1'b1;
        drop    = cmd_valid;
        state_d = ST_DONE;
      end
      ST_LINE: begin
        busy = 1'b1;
        drop = cmd_valid;
        // !ln_valid cannot occur in normal flow; leaving keeps the FSM safe.
        if (ln_last || !ln_valid) state_d = ST_DONE;
      end
      ST_RECT: begin
        busy = 1'b1;
        drop = cmd_valid;
        if ((cx == x_hi_q) && (cy == y_hi_q)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb      <= '0;
      rd_data <= '0;
      cx      <= '0;
      cy      <= '0;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_hi_q  <= '0;
    end else begin
      // Reads see the framebuffer before this edge's write.
      rd_data <= fb[{rd_row, 3'b000} +: FB_W];

      if (accept) begin
        cx     <= x1;
        cy     <= (cmd == CMD_CLEAR) ? 3'd0 : y1;
        x_lo_q <= x1;
        x_hi_q <= clip_end(x1, width);
        y_hi_q <= clip_end(y1, height);
      end

      case (state_q)
        ST_CLEAR: begin
          fb[{cy, 3'b000} +: FB_W] <= '0;
          cy <= cy + 3'd1;
        end
        ST_PIXEL: fb[{cy, cx}] <= 1'b1;
        ST_LINE:  if (ln_valid) fb[{ln_y, ln_x}] <= 1'b1;
        ST_RECT: begin
          fb[{cy, cx}] <= 1'b1;
          if (cx == x_hi_q) begin
            cx <= x_lo_q;
            cy <= cy + 3'd1;
          end else begin
            cx <= cx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_engine.sv
module tb_raster_engine;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [2:0] x1, y1, x2, y2, width, height, rd_row;
  logic [7:0] rd_data;
  logic       busy, done, drop;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_fb;   // reference framebuffer, bit y*8+x

  raster_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .x1        (x1),
    .y1        (y1),
    .x2        (x2),
    .y2        (y2),
    .width     (width),
    .height    (height),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic setpx(input int x, input int y);
    m_fb[y*8 + x] = 1'b1;
  endtask

  task automatic model_cmd(input logic [1:0] c, input int a1, input int b1,
                           input int a2, input int b2, input int w, input int h,
                           output int cyc);
    int adx, ady, sx, sy, n, xe, ye;
    cyc = 0;
    case (c)
      2'b00: begin m_fb = '0; cyc = 8; end
      2'b01: begin setpx(a1, b1); cyc = 1; end
      2'b10: begin
        adx = (a2 > a1) ? a2 - a1 : a1 - a2;
        ady = (b2 > b1) ? b2 - b1 : b1 - b2;
        sx  = (a2 >= a1) ? 1 : -1;
        sy  = (b2 >= b1) ? 1 : -1;
        n   = (adx > ady) ? adx : ady;
        // Ideal line sampled on the major axis, minor rounded half-up.
        for (int k = 0; k <= n; k++) begin
          if (n == 0)          setpx(a1, b1);
          else if (adx >= ady) setpx(a1 + sx*k, b1 + sy*((2*k*ady + adx) / (2*adx)));
          else                 setpx(a1 + sx*((2*k*adx + ady) / (2*ady)), b1 + sy*k);
        end
        cyc = n + 1;
      end
      default: begin
        xe = (a1 + w > 7) ? 7 : a1 + w;
        ye = (b1 + h > 7) ? 7 : b1 + h;
        for (int y = b1; y <= ye; y++)
          for (int x = a1; x <= xe; x++) setpx(x, y);
        cyc = (xe - a1 + 1) * (ye - b1 + 1);
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [1:0] c, input int a1, input int b1,
                       input int a2, input int b2, input int w, input int h);
    @(posedge clk); #1;
    cmd = c; x1 = 3'(a1); y1 = 3'(b1); x2 = 3'(a2); y2 = 3'(b2);
    width = 3'(w); height = 3'(h); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen,
                           output logic [7:0] rd_at, output logic [7:0] rd_nxt);
    cyc = 0; seen = 0; rd_at = '0; rd_nxt = '0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1;
        rd_at = rd_data;
        check("busy_during_done", 64'(busy), 64'd0);
      end else if (busy) begin
        cyc++;
      end
    end
    if (seen) begin
      @(negedge clk);
      rd_nxt = rd_data;
      check("done_pulse_width", 64'(done), 64'd0);
    end
  endtask

  task automatic run(input string nm, input logic [1:0] c, input int a1, input int b1,
                     input int a2, input int b2, input int w, input int h, input int exp_cyc);
    int cyc; bit seen; logic [7:0] ra, rn;
    issue(c, a1, b1, a2, b2, w, h);
    wait_done(cyc, seen, ra, rn);
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    check({nm, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic read_row(input int r, output logic [7:0] d);
    @(posedge clk); #1 rd_row = 3'(r);
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_rows(input string nm, input logic [63:0] exp);
    logic [7:0] d;
    for (int r = 0; r < 8; r++) begin
      read_row(r, d);
      check($sformatf("%s_row%0d", nm, r), 64'(d), 64'(exp[r*8 +: 8]));
    end
  endtask

  typedef struct {
    logic [1:0]  c;
    int          a1, b1, a2, b2, w, h;
    int          cyc;
    logic [63:0] rows;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc, ecyc, r;
    bit seen;
    logic [1:0] c;
    logic [7:0] ra, rn;
    int p[6];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd = '0; rd_row = '0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; width = '0; height = '0;

    tbl[0] = '{2'b01, 3, 5, 0, 0, 0, 0,  1, 64'h0000_0800_0000_0000};
    tbl[1] = '{2'b10, 0, 0, 7, 7, 0, 0,  8, 64'h8040_2010_0804_0201};
    tbl[2] = '{2'b11, 6, 6, 0, 0, 3, 3,  4, 64'hC0C0_0000_0000_0000};
    tbl[3] = '{2'b11, 0, 0, 0, 0, 7, 7, 64, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{2'b00, 0, 0, 0, 0, 0, 0,  8, 64'h0000_0000_0000_0000};
    tbl[5] = '{2'b10, 0, 7, 7, 0, 0, 0,  8, 64'h0102_0408_1020_4080};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check_rows("rst", 64'd0);

    // Directed vectors; fill (3) is followed directly by CLEAR (4).
    for (int i = 0; i < 6; i++) begin
      run($sformatf("vec%0d", i), tbl[i].c, tbl[i].a1, tbl[i].b1, tbl[i].a2,
          tbl[i].b2, tbl[i].w, tbl[i].h, tbl[i].cyc);
      check_rows($sformatf("vec%0d", i), tbl[i].rows);
      if (i != 3) run($sformatf("vec%0d_clr", i), 2'b00, 0, 0, 0, 0, 0, 0, 8);
    end

    // Command during busy is dropped and leaves the line intact.
    issue(2'b10, 0, 7, 7, 0, 0, 0);
    cmd = 2'b01; x1 = 3'd0; y1 = 3'd0; cmd_valid = 1'b1;
    @(negedge clk);
    check("drop_pulse", 64'(drop), 64'd1);
    check("drop_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    #1 check("drop_clears", 64'(drop), 64'd0);
    wait_done(cyc, seen, ra, rn);
    check("drop_done_seen", 64'(seen), 64'd1);
    check("drop_rest_cycles", 64'(cyc), 64'd7);
    check_rows("drop", 64'h0102_0408_1020_4080);

    // Read of a row coinciding with its write returns the old contents.
    run("rw_clr", 2'b00, 0, 0, 0, 0, 0, 0, 8);
    rd_row = 3'd5;
    issue(2'b01, 2, 5, 0, 0, 0, 0);
    wait_done(cyc, seen, ra, rn);
    check("rw_old_value", 64'(ra), 64'h00);
    check("rw_new_value", 64'(rn), 64'h04);

    // Reset in the third LINE cycle abandons the command.
    issue(2'b10, 0, 0, 7, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_data", 64'(rd_data), 64'd0);
    cyc = 0; r = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) cyc++;
      if (busy) r++;
    end
    check("mid_rst_no_done", 64'(cyc), 64'd0);
    check("mid_rst_no_busy", 64'(r), 64'd0);
    check_rows("mid_rst", 64'd0);

    // Random commands against the reference model.
    m_fb = '0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      c = (r == 0) ? 2'b00 : 2'((r % 3) + 1);
      for (int k = 0; k < 6; k++) p[k] = $urandom_range(0, 7);
      model_cmd(c, p[0], p[1], p[2], p[3], p[4], p[5], ecyc);
      run($sformatf("rnd%0d_c%0d", n, c), c, p[0], p[1], p[2], p[3], p[4], p[5], ecyc);
      check_rows($sformatf("rnd%0d", n), m_fb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
